// File: rtl/irf_pkg.sv
// Shared types and constants for the integer register-file forwarding control.
// Stage entries are kept all-zero when invalid so write_addr needs no extra masking.
package irf_pkg;

  localparam logic [2:0] SEL_RF  = 3'd0;
  localparam logic [2:0] SEL_E3  = 3'd1;
  localparam logic [2:0] SEL_E4  = 3'd2;
  localparam logic [2:0] SEL_MEM = 3'd3;
  localparam logic [2:0] SEL_WB  = 3'd4;

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } stage_t;

  function automatic logic stage_hit(input stage_t e, input logic [4:0] src);
    return e.valid && (e.dest == src);
  endfunction

endpackage

// File: rtl/irf_src_match.sv
// Per-operand bypass select and load-use hazard detection, youngest stage first.
// A load hit in E3/E4 reports a hazard and leaves the select at the register file.
module irf_src_match
  import irf_pkg::*;
(
  input  logic [4:0] src,
  input  logic       used,
  input  stage_t     e3,
  input  stage_t     e4,
  input  stage_t     mem,
  input  stage_t     wb,
  output logic [2:0] sel,
  output logic       hazard
);

  always_comb begin
    sel    = SEL_RF;
    hazard = 1'b0;
    if (used && (src != ZERO_REG)) begin
      if (stage_hit(e3, src)) begin
        if (e3.is_load) hazard = 1'b1;
        else            sel    = SEL_E3;
      end else if (stage_hit(e4, src)) begin
        if (e4.is_load) hazard = 1'b1;
        else            sel    = SEL_E4;
      end else if (stage_hit(mem, src)) begin
        sel = SEL_MEM;
      end else if (stage_hit(wb, src)) begin
        sel = SEL_WB;
      end
    end
  end

endmodule

// File: rtl/irf_forward_ctrl.sv
// Writer-side register-file control: destination tracking E3..WB, bypass selects,
// load-use issue stall, WB write port and a saturating stall-cycle counter.
module irf_forward_ctrl
  import irf_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [4:0]             src_a,
  input  logic [4:0]             src_b,
  input  logic                   src_a_used,
  input  logic                   src_b_used,
  input  logic [4:0]             dest,
  input  logic                   dest_en,
  input  logic                   is_load,
  input  logic                   flush,
  output logic [2:0]             mux3_sel,
  output logic [2:0]             mux4_sel,
  output logic                   write_en,
  output logic [4:0]             write_addr,
  output logic [STALL_CNT_W-1:0] stall_count
);

  stage_t r_e3, r_e4, r_mem, r_wb;
  logic [STALL_CNT_W-1:0] r_stall;

  logic   w_hazard_a, w_hazard_b, w_hazard, w_accept;
  stage_t w_new;

  irf_src_match u_match_a (
    .src(src_a), .used(src_a_used),
    .e3(r_e3), .e4(r_e4), .mem(r_mem), .wb(r_wb),
    .sel(mux3_sel), .hazard(w_hazard_a)
  );

  irf_src_match u_match_b (
    .src(src_b), .used(src_b_used),
    .e3(r_e3), .e4(r_e4), .mem(r_mem), .wb(r_wb),
    .sel(mux4_sel), .hazard(w_hazard_b)
  );

  assign w_hazard    = w_hazard_a || w_hazard_b;
  assign issue_ready = !w_hazard && !flush;
  assign w_accept    = issue_valid && issue_ready;

  always_comb begin
    w_new = '0;
    if (w_accept && dest_en && (dest != ZERO_REG)) begin
      w_new.valid   = 1'b1;
      w_new.dest    = dest;
      w_new.is_load = is_load;
    end
  end

  // Flush kills whatever sits in E3/E4 now; MEM/WB contents still retire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_e3    <= '0;
      r_e4    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_stall <= '0;
    end else begin
      r_e3  <= w_new;
      r_e4  <= flush ? '0 : r_e3;
      r_mem <= flush ? '0 : r_e4;
      r_wb  <= r_mem;
      if (issue_valid && w_hazard && !flush && (r_stall != '1))
        r_stall <= r_stall + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign write_en    = r_wb.valid;
  assign write_addr  = r_wb.valid ? r_wb.dest : 5'd0;
  assign stall_count = r_stall;

endmodule

// File: tb/tb_irf_forward_ctrl.sv
// Scenario bench for irf_forward_ctrl: expected outputs are queued as stimulus is
// driven and popped for comparison at the following falling edge.
module tb_irf_forward_ctrl;

  logic        clk, rst_n;
  logic        issue_valid, issue_ready;
  logic [4:0]  src_a, src_b, dest;
  logic        src_a_used, src_b_used, dest_en, is_load, flush;
  logic [2:0]  mux3_sel, mux4_sel;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] stall_count;

  // {ready[44], mux3[43:41], mux4[40:38], we[37], waddr[36:32], stall[31:0]}
  typedef struct packed {
    logic [44:0] v;
    logic [44:0] m;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  irf_forward_ctrl #(.STALL_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .src_a(src_a), .src_b(src_b),
    .src_a_used(src_a_used), .src_b_used(src_b_used),
    .dest(dest), .dest_en(dest_en), .is_load(is_load), .flush(flush),
    .mux3_sel(mux3_sel), .mux4_sel(mux4_sel),
    .write_en(write_en), .write_addr(write_addr),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic rdy, input logic [2:0] s3, input logic [2:0] s4,
                              input logic we, input logic [4:0] wa, input logic [31:0] st,
                              input logic skip_sel);
    exp_t e;
    e.v = {rdy, s3, s4, we, wa, st};
    e.m = '1;
    if (skip_sel) e.m[43:38] = 6'b0;
    return e;
  endfunction

  function automatic logic [44:0] observed();
    return {issue_ready, mux3_sel, mux4_sel, write_en, write_addr, stall_count};
  endfunction

  task automatic drive(input logic v, input logic [4:0] a, input logic au,
                       input logic [4:0] b, input logic bu, input logic [4:0] d,
                       input logic de, input logic ld, input logic fl, input exp_t e);
    issue_valid = v;  src_a = a; src_a_used = au; src_b = b; src_b_used = bu;
    dest = d; dest_en = de; is_load = ld; flush = fl;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    issue_valid = 0; src_a_used = 0; src_b_used = 0; dest_en = 0; flush = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [44:0] o;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rst_n = 1'b1;
      drive(1, 5'd1, 1, 5'd1, 1, 5'd1, 1, 1, 0, mk(1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); o = observed(); total++;
      if ((o & e.m) !== (e.v & e.m)) begin
        bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", c, o, e.v);
      end else $display("ok reset cyc=%0d out=%h", c, o);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_chain();
    exp_t e;
    logic [44:0] o;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) drive(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
      else drive(1, 5'd1, 1, 5'd0, 0, 5'd0, 0, 0, 0,
                 mk(1, (c < 5) ? 3'(c) : 3'd0, 0, c == 4, (c == 4) ? 5'd1 : 5'd0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); o = observed(); total++;
      if ((o & e.m) !== (e.v & e.m)) begin
        bad++; $display("FAIL alu_chain cyc=%0d got=%h exp=%h", c, o, e.v);
      end else $display("ok alu_chain cyc=%0d out=%h", c, o);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [44:0] o;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      case (c)
        0: drive(1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1, 0, mk(1, 0, 0, 0, 0, 0, 0));
        1: drive(1, 5'd0, 0, 5'd2, 1, 5'd0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
        2: drive(1, 5'd0, 0, 5'd2, 1, 5'd0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 1));
        3: drive(1, 5'd0, 0, 5'd2, 1, 5'd0, 0, 0, 0, mk(1, 0, 3, 0, 0, 2, 0));
        4: drive(0, 5'd0, 0, 5'd2, 1, 5'd0, 0, 0, 0, mk(1, 0, 4, 1, 5'd2, 2, 0));
        default: drive(0, 5'd0, 0, 5'd2, 1, 5'd0, 0, 0, 0, mk(1, 0, 0, 0, 0, 2, 0));
      endcase
      @(negedge clk);
      e = sb.pop_front(); o = observed(); total++;
      if ((o & e.m) !== (e.v & e.m)) begin
        bad++; $display("FAIL load_use cyc=%0d got=%h exp=%h", c, o, e.v);
      end else $display("ok load_use cyc=%0d out=%h", c, o);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    logic [44:0] o;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) drive(1, 5'd0, 0, 5'd0, 0, 5'd31, 1, 1, 0, mk(1, 0, 0, 0, 0, 0, 0));
      else drive(1, 5'd31, 1, 5'd31, 1, 5'd0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); o = observed(); total++;
      if ((o & e.m) !== (e.v & e.m)) begin
        bad++; $display("FAIL zero_reg cyc=%0d got=%h exp=%h", c, o, e.v);
      end else $display("ok zero_reg cyc=%0d out=%h", c, o);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [44:0] o;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      case (c)
        0, 1: drive(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        2: drive(1, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0));
        3: drive(0, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0, mk(1, 2, 2, 0, 0, 0, 0));
        4: drive(0, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0, mk(1, 3, 3, 1, 5'd3, 0, 0));
        5: drive(0, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0, mk(1, 4, 4, 1, 5'd3, 0, 0));
        default: drive(0, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
      endcase
      @(negedge clk);
      e = sb.pop_front(); o = observed(); total++;
      if ((o & e.m) !== (e.v & e.m)) begin
        bad++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, o, e.v);
      end else $display("ok back_to_back cyc=%0d out=%h", c, o);
      @(posedge clk); #1;
    end
  endtask

  // Younger ALU write of r5 in E3 shadows an older load of r5 in E4: no stall.
  task automatic test_youngest_over_load();
    exp_t e;
    logic [44:0] o;
    do_reset();
    for (int c = 0; c <= 2; c++) begin
      case (c)
        0: drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, mk(1, 0, 0, 0, 0, 0, 0));
        1: drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        default: drive(1, 5'd0, 0, 5'd5, 1, 5'd0, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0));
      endcase
      @(negedge clk);
      e = sb.pop_front(); o = observed(); total++;
      if ((o & e.m) !== (e.v & e.m)) begin
        bad++; $display("FAIL youngest cyc=%0d got=%h exp=%h", c, o, e.v);
      end else $display("ok youngest cyc=%0d out=%h", c, o);
      @(posedge clk); #1;
    end
  endtask

  // r7 reaches MEM as the flush hits a load of r4 in E3; r7 must still write back.
  task automatic test_flush();
    exp_t e;
    logic [44:0] o;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      case (c)
        0: drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        1: drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        2: drive(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 0, mk(1, 0, 0, 0, 0, 0, 0));
        3: drive(1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
        4: drive(1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 0, mk(1, 0, 0, 1, 5'd7, 0, 0));
        default: drive(0, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
      endcase
      @(negedge clk);
      e = sb.pop_front(); o = observed(); total++;
      if ((o & e.m) !== (e.v & e.m)) begin
        bad++; $display("FAIL flush cyc=%0d got=%h exp=%h", c, o, e.v);
      end else $display("ok flush cyc=%0d out=%h", c, o);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 0; src_a = 0; src_b = 0; src_a_used = 0; src_b_used = 0;
    dest = 0; dest_en = 0; is_load = 0; flush = 0;
    @(posedge clk); #1;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_zero_reg();
    test_back_to_back();
    test_youngest_over_load();
    test_flush();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d left exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
